// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared constants and helpers for the key debounce array.
//   - Default cycle counts for the 12 MHz audio clock domain.
//   - clog2_min1(): counter width helper that never returns 0, so a
//     degenerate parameter still yields a legal 1-bit vector.
// No ports (package).
// -----------------------------------------------------------------------------
package key_pkg;

  // 12 MHz defaults: 1 ms debounce, 1 s long press, 200 ms auto-repeat.
  localparam int KEY_DEB_CYCLES_12M    = 12000;
  localparam int KEY_LONG_CYCLES_12M   = 12000000;
  localparam int KEY_REPEAT_CYCLES_12M = 2400000;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// -----------------------------------------------------------------------------
// debounce_chan
// One key channel: two-flop synchroniser, glitch-rejecting debounce counter,
// long-press hold counter and (optionally) an auto-repeat counter.
//
// Optional feature macro: KEY_AUTOREPEAT_EN
//   defined   -> after the long-press pulse, o_press re-pulses every
//                REPEAT_CYCLES while the key stays pressed.
//   undefined -> no repeat logic; o_press pulses once per press.
//
// Ports:
//   i_clk      clock
//   i_rst      asynchronous reset, active-high
//   i_key_n    raw key, active-low, asynchronous to i_clk
//   o_level    debounced state, 1 = pressed
//   o_press    one-cycle pulse on accepted press (and repeats, if enabled)
//   o_release  one-cycle pulse on accepted release
//   o_long     one-cycle pulse once a press has been held LONG_CYCLES
// -----------------------------------------------------------------------------
module debounce_chan
  import key_pkg::*;
#(
  parameter int DEB_CYCLES    = KEY_DEB_CYCLES_12M,
  parameter int LONG_CYCLES   = KEY_LONG_CYCLES_12M,
  parameter int REPEAT_CYCLES = KEY_REPEAT_CYCLES_12M
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int DW = clog2_min1(DEB_CYCLES);
  localparam int HW = clog2_min1(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DC_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HC_LAST = HW'(LONG_CYCLES);

  // Elaboration-time parameter sanity.
  if (DEB_CYCLES < 2) begin : g_chk_deb
    $error("debounce_chan: DEB_CYCLES must be >= 2");
  end
  if (LONG_CYCLES <= DEB_CYCLES) begin : g_chk_long
    $error("debounce_chan: LONG_CYCLES must exceed DEB_CYCLES");
  end
  if (REPEAT_CYCLES < 1) begin : g_chk_rep
    $error("debounce_chan: REPEAT_CYCLES must be >= 1");
  end

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          st_q, st_d;          // accepted state, active-low
  logic [DW-1:0] dc_q, dc_d;          // debounce counter
  logic [HW-1:0] hc_q, hc_d;          // hold counter, saturates at LONG_CYCLES
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          pressed;

`ifdef KEY_AUTOREPEAT_EN
  localparam int RW = clog2_min1(REPEAT_CYCLES);
  localparam logic [RW-1:0] RC_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rc_q, rc_d;          // repeat counter
`endif

  assign pressed = ~st_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    sync1_d   = i_key_n;
    sync2_d   = sync1_q;
    st_d      = st_q;
    dc_d      = '0;
    hc_d      = hc_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;

    // Debounce: any agreeing cycle restarts the count (dc_d default 0).
    if (sync2_q != st_q) begin
      if (dc_q == DC_LAST) begin
        st_d      = sync2_q;
        press_d   = ~sync2_q;
        release_d = sync2_q;
      end else begin
        dc_d = dc_q + 1'b1;
      end
    end

    // Hold counter: saturation means o_long cannot fire again until the
    // key is released and hc clears.
    if (!pressed) begin
      hc_d = '0;
    end else if (hc_q != HC_LAST) begin
      hc_d   = hc_q + 1'b1;
      long_d = (hc_d == HC_LAST);
    end

`ifdef KEY_AUTOREPEAT_EN
    // Repeat phase runs only once the hold counter has saturated. A repeat
    // that lands on the release-accept edge is dropped so press and release
    // never coincide.
    rc_d = '0;
    if (pressed && (hc_q == HC_LAST)) begin
      if (rc_q == RC_LAST) begin
        if (!release_d) press_d = 1'b1;
      end else begin
        rc_d = rc_q + 1'b1;
      end
    end
`endif
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q   <= 1'b1;              // released
      sync2_q   <= 1'b1;
      st_q      <= 1'b1;
      dc_q      <= '0;
      hc_q      <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      st_q      <= st_d;
      dc_q      <= dc_d;
      hc_q      <= hc_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) rc_q <= '0;
    else       rc_q <= rc_d;
  end
`endif

  assign o_level   = pressed;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;

endmodule

// File: rtl/key_debounce_array.sv
// -----------------------------------------------------------------------------
// key_debounce_array
// Multi-channel push-button conditioner for DE2-115 KEY/SW inputs in the
// 12 MHz audio clock domain. Each channel is an independent debounce_chan.
//
// Optional feature macro: KEY_AUTOREPEAT_EN (auto-repeat of o_press after a
// long press; see debounce_chan).
//
// Ports:
//   i_clk        clock (CLK_12M)
//   i_rst        asynchronous reset, active-high
//   i_keys       raw keys, active-low, asynchronous
//   o_level      debounced state per key, 1 = pressed
//   o_press      one-cycle press pulse per key
//   o_release    one-cycle release pulse per key
//   o_long       one-cycle long-press pulse per key
//   o_any_press  OR of o_press, same cycle
// -----------------------------------------------------------------------------
module key_debounce_array
  import key_pkg::*;
#(
  parameter int NUM_KEYS      = 4,
  parameter int DEB_CYCLES    = KEY_DEB_CYCLES_12M,
  parameter int LONG_CYCLES   = KEY_LONG_CYCLES_12M,
  parameter int REPEAT_CYCLES = KEY_REPEAT_CYCLES_12M
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NUM_KEYS-1:0] i_keys,
  output logic [NUM_KEYS-1:0] o_level,
  output logic [NUM_KEYS-1:0] o_press,
  output logic [NUM_KEYS-1:0] o_release,
  output logic [NUM_KEYS-1:0] o_long,
  output logic                o_any_press
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    debounce_chan #(
      .DEB_CYCLES    (DEB_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_chan (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_key_n   (i_keys[i]),
      .o_level   (o_level[i]),
      .o_press   (o_press[i]),
      .o_release (o_release[i]),
      .o_long    (o_long[i])
    );
  end

  // Combinational OR of registered pulses: same cycle as o_press.
  assign o_any_press = |o_press;

endmodule

// File: tb/tb_key_debounce_array.sv
// -----------------------------------------------------------------------------
// tb_key_debounce_array
// Bench for key_debounce_array with NUM_KEYS=4, DEB_CYCLES=4, LONG_CYCLES=20,
// REPEAT_CYCLES=8. Every tick drives inputs, waits one rising edge, advances a
// timestamp-based reference model and compares all outputs 1 ns later.
// A reset/power-up vector table and hand sequences add explicit timing checks;
// a randomized phase exercises the model against arbitrary key traffic.
// -----------------------------------------------------------------------------
module tb_key_debounce_array;

  localparam int NK   = 4;
  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REP  = 8;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic [NK-1:0] i_keys = '1;
  logic [NK-1:0] o_level, o_press, o_release, o_long;
  logic          o_any_press;

  key_debounce_array #(
    .NUM_KEYS      (NK),
    .DEB_CYCLES    (DEB),
    .LONG_CYCLES   (LONG),
    .REPEAT_CYCLES (REP)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_keys      (i_keys),
    .o_level     (o_level),
    .o_press     (o_press),
    .o_release   (o_release),
    .o_long      (o_long),
    .o_any_press (o_any_press)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int tick_n   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s tick=%0d got=%0h expected=%0h", name, tick_n, act, exp);
    else
      n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. The synchroniser is a two-stage delay line; a level
  // change is accepted when the last DEB synchronised samples all equal a
  // value that differs from the accepted state. Long-press and repeat events
  // are pure timestamp arithmetic from the accepted press edge.
  // ---------------------------------------------------------------------------
  bit            m_s1 [NK];
  bit            m_s2 [NK];
  bit            m_st [NK];
  bit            m_win[NK][$];
  int            m_pe [NK];       // tick of accepted press, -1 when released
  logic [NK-1:0] e_level, e_press, e_release, e_long;

  task automatic model_step(input logic rst, input logic [NK-1:0] keys);
    e_press   = '0;
    e_release = '0;
    e_long    = '0;
    for (int k = 0; k < NK; k++) begin
      bit s;
      bit same;
      bit acc;
      if (rst) begin
        m_s1[k] = 1'b1;
        m_s2[k] = 1'b1;
        m_st[k] = 1'b1;
        m_win[k].delete();
        m_pe[k] = -1;
      end else begin
        s       = m_s2[k];
        m_s2[k] = m_s1[k];
        m_s1[k] = keys[k];
        m_win[k].push_back(s);
        if (m_win[k].size() > DEB) void'(m_win[k].pop_front());
        same = (m_win[k].size() == DEB);
        for (int j = 0; j < m_win[k].size(); j++)
          if (m_win[k][j] != s) same = 1'b0;
        acc = same && (s != m_st[k]);
        if (acc && !s) e_press[k]   = 1'b1;
        if (acc &&  s) e_release[k] = 1'b1;
        if (m_pe[k] >= 0 && tick_n == m_pe[k] + LONG) e_long[k] = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
        if (m_pe[k] >= 0 && !acc && tick_n > m_pe[k] + LONG &&
            ((tick_n - m_pe[k] - LONG) % REP) == 0)
          e_press[k] = 1'b1;
`endif
        if (acc) begin
          m_st[k] = s;
          m_pe[k] = s ? -1 : tick_n;
        end
      end
    end
    for (int k = 0; k < NK; k++) e_level[k] = ~m_st[k];
  endtask

  // One clock: drive, edge, model, sample 1 ns after the edge, compare.
  task automatic tick(input logic rst, input logic [NK-1:0] keys);
    i_rst  = rst;
    i_keys = keys;
    @(posedge i_clk);
    tick_n++;
    model_step(rst, keys);
    #1;
    check("o_level",     32'(o_level),     32'(e_level));
    check("o_press",     32'(o_press),     32'(e_press));
    check("o_release",   32'(o_release),   32'(e_release));
    check("o_long",      32'(o_long),      32'(e_long));
    check("o_any_press", 32'(o_any_press), 32'(|e_press));
  endtask

  // ---------------------------------------------------------------------------
  // Reset / power-up vector table: keys held pressed through reset show up as
  // a fresh press on the 6th edge after reset release (sample, 2nd sync
  // stage, then DEB agreeing cycles).
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          rst;
    logic [NK-1:0] keys;
    logic [NK-1:0] exp_level;
    logic [NK-1:0] exp_press;
    logic          exp_any;
  } vec_t;

  vec_t vecs[11];

  int press_at, release_at, long_at, n_press, n_release, n_long, n_any;
  logic [NK-1:0] press_vec;
  int exp_presses;
  logic [NK-1:0] rkeys;
  logic          rrst;

  initial begin
    for (int k = 0; k < NK; k++) m_pe[k] = -1;

    for (int r = 0; r < 3; r++) vecs[r] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    for (int j = 1; j <= 8; j++)
      vecs[2 + j] = '{1'b0, 4'b0000,
                      (j >= 6) ? 4'b1111 : 4'b0000,
                      (j == 6) ? 4'b1111 : 4'b0000,
                      (j == 6)};

    // 1. Reset with all keys held.
    for (int r = 0; r < 11; r++) begin
      tick(vecs[r].rst, vecs[r].keys);
      check("tbl_level", 32'(o_level),     32'(vecs[r].exp_level));
      check("tbl_press", 32'(o_press),     32'(vecs[r].exp_press));
      check("tbl_any",   32'(o_any_press), 32'(vecs[r].exp_any));
    end
    for (int i = 0; i < 12; i++) tick(1'b0, 4'b1111);

    // 2. Clean press/release on key 1.
    press_at = -1; release_at = -1; n_press = 0; n_release = 0;
    for (int i = 0; i < 22; i++) begin
      tick(1'b0, (i < 10) ? 4'b1101 : 4'b1111);
      if (o_press[1])   begin n_press++;   if (press_at < 0)   press_at = i;   end
      if (o_release[1]) begin n_release++; if (release_at < 0) release_at = i; end
    end
    check("k1_press_lat",   32'(press_at),   32'd5);
    check("k1_release_lat", 32'(release_at), 32'd15);
    check("k1_press_cnt",   32'(n_press),    32'd1);
    check("k1_release_cnt", 32'(n_release),  32'd1);

    // 3. Bounce on key 0: last transition at i=4.
    press_at = -1; n_press = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1'b0, {3'b111, (i < 4) ? 1'(i % 2) : 1'b0});
      if (o_press[0]) begin n_press++; if (press_at < 0) press_at = i; end
    end
    check("bounce_press_lat", 32'(press_at), 32'd9);
    check("bounce_press_cnt", 32'(n_press),  32'd1);
    for (int i = 0; i < 10; i++) tick(1'b0, 4'b1111);

    // 4. Long press on key 2, 40 cycles.
`ifdef KEY_AUTOREPEAT_EN
    exp_presses = 3;
`else
    exp_presses = 1;
`endif
    press_at = -1; long_at = -1; n_press = 0; n_long = 0;
    for (int i = 0; i < 52; i++) begin
      tick(1'b0, (i < 40) ? 4'b1011 : 4'b1111);
      if (o_press[2]) begin n_press++; if (press_at < 0) press_at = i; end
      if (o_long[2])  begin n_long++;  if (long_at < 0)  long_at = i;  end
    end
    check("long_cnt",       32'(n_long),            32'd1);
    check("long_after_lvl", 32'(long_at - press_at), 32'(LONG));
    check("long_press_cnt", 32'(n_press),           32'(exp_presses));

    // 5. Simultaneous press of keys 0 and 3.
    n_any = 0; press_vec = '0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 4'b0110);
      if (o_any_press) begin n_any++; press_vec = o_press; end
    end
    check("simul_any_cnt",  32'(n_any),     32'd1);
    check("simul_press_vec", 32'(press_vec), 32'b1001);
    for (int i = 0; i < 12; i++) tick(1'b0, 4'b1111);

    // 6. Reset mid-debounce of key 1 (count 2), key held through reset.
    press_at = -1; n_press = 0;
    for (int i = 0; i < 15; i++) begin
      tick(i == 4, 4'b1101);
      if (o_press[1]) begin n_press++; if (press_at < 0) press_at = i; end
    end
    check("rst_mid_press_lat", 32'(press_at), 32'd10);
    check("rst_mid_press_cnt", 32'(n_press),  32'd1);
    for (int i = 0; i < 12; i++) tick(1'b0, 4'b1111);

    // Randomized traffic: slower toggle rates on higher keys give long holds.
    rkeys = '1;
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < NK; k++)
        if ($urandom_range(0, (4 << k)) == 0) rkeys[k] = ~rkeys[k];
      rrst = ($urandom_range(0, 199) == 0);
      tick(rrst, rkeys);
    end
    for (int i = 0; i < 10; i++) tick(1'b0, 4'b1111);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
